// File: rtl/bitmask_slot_allocator.sv
// bitmask_slot_allocator
// Registered allocator for WORD_WIDTH slots tracked as a busy bitmap.
// The lowest free slot is offered on a valid/ready handshake. Slots come back
// through a multi-hot free port. Each cycle the offer is rebuilt from the next
// busy bitmap: busy ^ (busy + 1) is the thermometer mask up to the rightmost 0
// bit, and masking it with ~busy leaves that 0 bit as a one-hot offer.
//
// Handshake: a slot is taken on a rising edge where alloc_valid && alloc_ready.
// alloc_ready has no effect while alloc_valid is low. While alloc_valid is high
// and alloc_ready is low, the offer may still move to a lower slot if one is
// freed. Consumers therefore sample the offer only on the cycle of the take.
module bitmask_slot_allocator #(
  parameter int                    WORD_WIDTH    = 8,
  parameter logic [WORD_WIDTH-1:0] RESERVED_MASK = '0,
  parameter int                    INDEX_WIDTH   = $clog2(WORD_WIDTH),
  parameter int                    COUNT_WIDTH   = $clog2(WORD_WIDTH + 1)
) (
  input  logic                   clock,
  input  logic                   clear_n,
  output logic                   alloc_valid,
  input  logic                   alloc_ready,
  output logic [WORD_WIDTH-1:0]  alloc_onehot,
  output logic [INDEX_WIDTH-1:0] alloc_index,
  output logic [WORD_WIDTH-1:0]  alloc_thermo,
  input  logic                   free_valid,
  input  logic [WORD_WIDTH-1:0]  free_mask,
  output logic [COUNT_WIDTH-1:0] free_count,
  output logic                   full,
  output logic                   free_error
);

  logic [WORD_WIDTH-1:0]  busy;
  logic                   take;
  logic [WORD_WIDTH-1:0]  good_free;
  logic                   bad_free;
  logic [WORD_WIDTH-1:0]  busy_next;
  logic [WORD_WIDTH-1:0]  thermo_next;
  logic [WORD_WIDTH-1:0]  onehot_next;
  logic                   has_free_next;
  logic [INDEX_WIDTH-1:0] index_next;
  logic [COUNT_WIDTH-1:0] count_next;

  // Next busy bitmap and the offer derived from it.
  // Reserved bits are never released and never offered. A slot is only freed
  // if it is busy now, so freeing the slot being taken this cycle counts as a
  // bad bit while the take still completes.
  always_comb begin
    take          = alloc_valid & alloc_ready;
    good_free     = free_valid ? (free_mask & busy & ~RESERVED_MASK) : '0;
    bad_free      = free_valid & (|(free_mask & (~busy | RESERVED_MASK)));
    busy_next     = (busy & ~good_free) | (take ? alloc_onehot : '0);
    thermo_next   = busy_next ^ (busy_next + WORD_WIDTH'(1));
    onehot_next   = thermo_next & ~busy_next;
    has_free_next = ~(&busy_next);
    index_next    = '0;
    count_next    = '0;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      if (onehot_next[i]) index_next = index_next | INDEX_WIDTH'(i);
      if (!busy_next[i])  count_next = count_next + COUNT_WIDTH'(1);
    end
  end

  // Busy bitmap, offer registers, status and sticky error flag.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      busy         <= RESERVED_MASK;
      alloc_valid  <= 1'b0;
      alloc_onehot <= '0;
      alloc_index  <= '0;
      alloc_thermo <= '0;
      free_count   <= '0;
      full         <= 1'b1;
      free_error   <= 1'b0;
    end else begin
      busy         <= busy_next;
      alloc_valid  <= has_free_next;
      alloc_onehot <= onehot_next;
      alloc_index  <= index_next;
      alloc_thermo <= has_free_next ? thermo_next : '0;
      free_count   <= count_next;
      full         <= ~has_free_next;
      if (bad_free) free_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bitmask_slot_allocator.sv
// Directed bench for bitmask_slot_allocator. The bench uses two instances:
// the default 8-slot pool, and an 8-slot pool with slots 0 and 7 reserved.
module tb_bitmask_slot_allocator;

  logic       clk;

  // Default instance.
  logic       a_clear_n, a_valid, a_ready, a_free_valid, a_full, a_error;
  logic [7:0] a_onehot, a_thermo, a_free_mask;
  logic [2:0] a_index;
  logic [3:0] a_count;

  // Instance with RESERVED_MASK = 0x81.
  logic       r_clear_n, r_valid, r_ready, r_free_valid, r_full, r_error;
  logic [7:0] r_onehot, r_thermo, r_free_mask;
  logic [2:0] r_index;
  logic [3:0] r_count;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  bitmask_slot_allocator #(.WORD_WIDTH(8), .RESERVED_MASK(8'h00)) dut (
    .clock(clk), .clear_n(a_clear_n),
    .alloc_valid(a_valid), .alloc_ready(a_ready), .alloc_onehot(a_onehot),
    .alloc_index(a_index), .alloc_thermo(a_thermo),
    .free_valid(a_free_valid), .free_mask(a_free_mask),
    .free_count(a_count), .full(a_full), .free_error(a_error)
  );

  bitmask_slot_allocator #(.WORD_WIDTH(8), .RESERVED_MASK(8'h81)) dut_r (
    .clock(clk), .clear_n(r_clear_n),
    .alloc_valid(r_valid), .alloc_ready(r_ready), .alloc_onehot(r_onehot),
    .alloc_index(r_index), .alloc_thermo(r_thermo),
    .free_valid(r_free_valid), .free_mask(r_free_mask),
    .free_count(r_count), .full(r_full), .free_error(r_error)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and sample 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_clear_n = 1'b0;
    tick();
    tick();
    chk_cnt++; if (a_valid !== 1'b0)  $display("FAIL reset_valid got %b exp 0", a_valid); else pass_cnt++;
    chk_cnt++; if (a_onehot !== 8'h00) $display("FAIL reset_onehot got %h exp 00", a_onehot); else pass_cnt++;
    chk_cnt++; if (a_index !== 3'd0)  $display("FAIL reset_index got %0d exp 0", a_index); else pass_cnt++;
    chk_cnt++; if (a_thermo !== 8'h00) $display("FAIL reset_thermo got %h exp 00", a_thermo); else pass_cnt++;
    chk_cnt++; if (a_count !== 4'd0)  $display("FAIL reset_count got %0d exp 0", a_count); else pass_cnt++;
    chk_cnt++; if (a_full !== 1'b1)   $display("FAIL reset_full got %b exp 1", a_full); else pass_cnt++;
    chk_cnt++; if (a_error !== 1'b0)  $display("FAIL reset_error got %b exp 0", a_error); else pass_cnt++;
    a_clear_n = 1'b1;
    tick();
    chk_cnt++; if (a_valid !== 1'b1)  $display("FAIL first_offer_valid got %b exp 1", a_valid); else pass_cnt++;
    chk_cnt++; if (a_onehot !== 8'h01) $display("FAIL first_offer_onehot got %h exp 01", a_onehot); else pass_cnt++;
    chk_cnt++; if (a_thermo !== 8'h01) $display("FAIL first_offer_thermo got %h exp 01", a_thermo); else pass_cnt++;
    chk_cnt++; if (a_count !== 4'd8)  $display("FAIL first_offer_count got %0d exp 8", a_count); else pass_cnt++;
    chk_cnt++; if (a_full !== 1'b0)   $display("FAIL first_offer_full got %b exp 0", a_full); else pass_cnt++;
  endtask

  // Take every slot on consecutive cycles, then one more cycle with ready high.
  task automatic test_back_to_back();
    logic [7:0] exp_oh;
    logic [7:0] exp_th;
    a_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_oh = 8'h01 << i;
      exp_th = (exp_oh << 1) - 8'h01;
      chk_cnt++; if (a_onehot !== exp_oh) $display("FAIL b2b_onehot[%0d] got %h exp %h", i, a_onehot, exp_oh); else pass_cnt++;
      chk_cnt++; if (a_index !== 3'(i))   $display("FAIL b2b_index[%0d] got %0d exp %0d", i, a_index, i); else pass_cnt++;
      chk_cnt++; if (a_thermo !== exp_th) $display("FAIL b2b_thermo[%0d] got %h exp %h", i, a_thermo, exp_th); else pass_cnt++;
      chk_cnt++; if (a_count !== 4'(8 - i)) $display("FAIL b2b_count[%0d] got %0d exp %0d", i, a_count, 8 - i); else pass_cnt++;
      tick();
    end
    tick();
    a_ready = 1'b0;
    chk_cnt++; if (a_valid !== 1'b0)  $display("FAIL b2b_end_valid got %b exp 0", a_valid); else pass_cnt++;
    chk_cnt++; if (a_full !== 1'b1)   $display("FAIL b2b_end_full got %b exp 1", a_full); else pass_cnt++;
    chk_cnt++; if (a_count !== 4'd0)  $display("FAIL b2b_end_count got %0d exp 0", a_count); else pass_cnt++;
    chk_cnt++; if (a_onehot !== 8'h00) $display("FAIL b2b_end_onehot got %h exp 00", a_onehot); else pass_cnt++;
    chk_cnt++; if (a_thermo !== 8'h00) $display("FAIL b2b_end_thermo got %h exp 00", a_thermo); else pass_cnt++;
    chk_cnt++; if (a_index !== 3'd0)  $display("FAIL b2b_end_index got %0d exp 0", a_index); else pass_cnt++;
  endtask

  // Starting from 0xFF, free 0xA8 so that busy becomes 0x57.
  task automatic test_offer_pattern();
    a_free_valid = 1'b1; a_free_mask = 8'hA8;
    tick();
    a_free_valid = 1'b0; a_free_mask = 8'h00;
    chk_cnt++; if (a_onehot !== 8'h08) $display("FAIL p57_onehot got %h exp 08", a_onehot); else pass_cnt++;
    chk_cnt++; if (a_thermo !== 8'h0F) $display("FAIL p57_thermo got %h exp 0F", a_thermo); else pass_cnt++;
    chk_cnt++; if (a_index !== 3'd3)  $display("FAIL p57_index got %0d exp 3", a_index); else pass_cnt++;
    chk_cnt++; if (a_count !== 4'd3)  $display("FAIL p57_count got %0d exp 3", a_count); else pass_cnt++;
    chk_cnt++; if (a_error !== 1'b0)  $display("FAIL p57_error got %b exp 0", a_error); else pass_cnt++;
  endtask

  // Fill up to 0xFF, free 0x24 while not ready, then take both freed slots.
  task automatic test_free_refill();
    a_ready = 1'b1;
    tick(); tick(); tick();
    a_ready = 1'b0;
    chk_cnt++; if (a_full !== 1'b1) $display("FAIL refill_full0 got %b exp 1", a_full); else pass_cnt++;
    a_free_valid = 1'b1; a_free_mask = 8'h24;
    tick();
    a_free_valid = 1'b0; a_free_mask = 8'h00;
    chk_cnt++; if (a_onehot !== 8'h04) $display("FAIL refill_onehot1 got %h exp 04", a_onehot); else pass_cnt++;
    chk_cnt++; if (a_thermo !== 8'h07) $display("FAIL refill_thermo1 got %h exp 07", a_thermo); else pass_cnt++;
    chk_cnt++; if (a_count !== 4'd2)  $display("FAIL refill_count1 got %0d exp 2", a_count); else pass_cnt++;
    a_ready = 1'b1;
    tick();
    chk_cnt++; if (a_onehot !== 8'h20) $display("FAIL refill_onehot2 got %h exp 20", a_onehot); else pass_cnt++;
    chk_cnt++; if (a_thermo !== 8'h3F) $display("FAIL refill_thermo2 got %h exp 3F", a_thermo); else pass_cnt++;
    chk_cnt++; if (a_index !== 3'd5)  $display("FAIL refill_index2 got %0d exp 5", a_index); else pass_cnt++;
    tick();
    a_ready = 1'b0;
    chk_cnt++; if (a_full !== 1'b1)  $display("FAIL refill_full3 got %b exp 1", a_full); else pass_cnt++;
    chk_cnt++; if (a_valid !== 1'b0) $display("FAIL refill_valid3 got %b exp 0", a_valid); else pass_cnt++;
    chk_cnt++; if (a_error !== 1'b0) $display("FAIL refill_error got %b exp 0", a_error); else pass_cnt++;
  endtask

  // busy=0x0F with offer 0x10; take while freeing 0x11 in the same cycle.
  task automatic test_free_take_collision();
    a_free_valid = 1'b1; a_free_mask = 8'hF0;
    tick();
    chk_cnt++; if (a_onehot !== 8'h10) $display("FAIL coll_setup_onehot got %h exp 10", a_onehot); else pass_cnt++;
    a_free_mask = 8'h11; a_ready = 1'b1;
    tick();
    a_free_valid = 1'b0; a_free_mask = 8'h00; a_ready = 1'b0;
    chk_cnt++; if (a_error !== 1'b1)  $display("FAIL coll_error got %b exp 1", a_error); else pass_cnt++;
    chk_cnt++; if (a_onehot !== 8'h01) $display("FAIL coll_onehot got %h exp 01", a_onehot); else pass_cnt++;
    chk_cnt++; if (a_thermo !== 8'h01) $display("FAIL coll_thermo got %h exp 01", a_thermo); else pass_cnt++;
    chk_cnt++; if (a_count !== 4'd4)  $display("FAIL coll_count got %0d exp 4", a_count); else pass_cnt++;
    tick(); tick();
    chk_cnt++; if (a_error !== 1'b1)  $display("FAIL coll_error_sticky got %b exp 1", a_error); else pass_cnt++;
  endtask

  // Grow busy to 0x3F (from 0x1E), then assert reset during a take.
  task automatic test_reset_mid_take();
    a_ready = 1'b1;
    tick(); tick();
    chk_cnt++; if (a_onehot !== 8'h40) $display("FAIL rmt_onehot got %h exp 40", a_onehot); else pass_cnt++;
    a_clear_n = 1'b0;
    tick();
    a_clear_n = 1'b1;
    chk_cnt++; if (a_valid !== 1'b0)  $display("FAIL rmt_valid got %b exp 0", a_valid); else pass_cnt++;
    chk_cnt++; if (a_error !== 1'b0)  $display("FAIL rmt_error got %b exp 0", a_error); else pass_cnt++;
    chk_cnt++; if (a_full !== 1'b1)   $display("FAIL rmt_full got %b exp 1", a_full); else pass_cnt++;
    tick();
    a_ready = 1'b0;
    chk_cnt++; if (a_valid !== 1'b1)  $display("FAIL rmt_offer_valid got %b exp 1", a_valid); else pass_cnt++;
    chk_cnt++; if (a_index !== 3'd0)  $display("FAIL rmt_offer_index got %0d exp 0", a_index); else pass_cnt++;
    chk_cnt++; if (a_count !== 4'd8)  $display("FAIL rmt_offer_count got %0d exp 8", a_count); else pass_cnt++;
  endtask

  // Reserved slots 0 and 7: never offered, never freed.
  task automatic test_reserved();
    logic [7:0] exp_oh;
    r_clear_n = 1'b1;
    tick();
    chk_cnt++; if (r_onehot !== 8'h02) $display("FAIL rsv_onehot got %h exp 02", r_onehot); else pass_cnt++;
    chk_cnt++; if (r_index !== 3'd1)  $display("FAIL rsv_index got %0d exp 1", r_index); else pass_cnt++;
    chk_cnt++; if (r_thermo !== 8'h03) $display("FAIL rsv_thermo got %h exp 03", r_thermo); else pass_cnt++;
    chk_cnt++; if (r_count !== 4'd6)  $display("FAIL rsv_count got %0d exp 6", r_count); else pass_cnt++;
    r_free_valid = 1'b1; r_free_mask = 8'h80;
    tick();
    r_free_valid = 1'b0; r_free_mask = 8'h00;
    chk_cnt++; if (r_error !== 1'b1)  $display("FAIL rsv_error got %b exp 1", r_error); else pass_cnt++;
    chk_cnt++; if (r_onehot !== 8'h02) $display("FAIL rsv_after_free_onehot got %h exp 02", r_onehot); else pass_cnt++;
    chk_cnt++; if (r_count !== 4'd6)  $display("FAIL rsv_after_free_count got %0d exp 6", r_count); else pass_cnt++;
    r_ready = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      exp_oh = 8'h01 << i;
      chk_cnt++; if (r_onehot !== exp_oh) $display("FAIL rsv_take_onehot[%0d] got %h exp %h", i, r_onehot, exp_oh); else pass_cnt++;
      tick();
    end
    r_ready = 1'b0;
    chk_cnt++; if (r_full !== 1'b1)  $display("FAIL rsv_full got %b exp 1", r_full); else pass_cnt++;
    chk_cnt++; if (r_valid !== 1'b0) $display("FAIL rsv_valid got %b exp 0", r_valid); else pass_cnt++;
    chk_cnt++; if (r_count !== 4'd0) $display("FAIL rsv_count_end got %0d exp 0", r_count); else pass_cnt++;
  endtask

  initial begin
    a_clear_n = 1'b0; a_ready = 1'b0; a_free_valid = 1'b0; a_free_mask = 8'h00;
    r_clear_n = 1'b0; r_ready = 1'b0; r_free_valid = 1'b0; r_free_mask = 8'h00;
    test_reset();
    test_back_to_back();
    test_offer_pattern();
    test_free_refill();
    test_free_take_collision();
    test_reset_mid_take();
    test_reserved();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
